mmu_tx_shaper: RTL and testbench
================================

Name: mmu_tx_shaper

Overview:
- TX-side counterpart of the RX bucket: a token-bucket rate shaper between tx_bd (frame descriptor source) and the TX datapath.
- Tokens (bytes) refill every 1 us tick at a CPU-programmed rate, up to a programmed depth.
- A frame is admitted only when enough tokens are present and the in-flight frame count is below its limit.
- Reports an admitted-frame count and sticky errors to the CPU.

Parameters:
- LEN_WIDTH, 14, frame length width in bytes.
- TOKEN_WIDTH, 20, token counter width.
- MAX_INFLIGHT, 64, maximum number of admitted frames whose tx_done has not yet returned.
- STALL_MS_US, 1000, number of 1 us ticks forming the 1 ms stall window.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tx_req_vld  in  1  tx_bd frame request valid.
- tx_req_len  in  LEN_WIDTH  frame length in bytes; stable while vld is high.
- tx_req_rdy  out  1  admission ready; a frame is accepted on vld&rdy.
- tx_done  in  1  one-cycle pulse: one admitted frame has left the datapath.
- reg_shaper_en  in  1  1 = shaping on; 0 = token check bypassed.
- reg_timer_1us_cfg  in  8  clk_sys cycles per 1 us.
- reg_token_rate  in  16  bytes added per tick.
- reg_token_depth  in  TOKEN_WIDTH  bucket ceiling.
- reg_err_clr  in  1  pulse that clears reg_shaper_err.
- reg_tx_frm_cnt  out  32  accepted-frame counter.
- reg_inflight_cnt  out  7  current in-flight count.
- reg_shaper_err  out  2  sticky errors: [0] tx_done with in-flight count 0; [1] request stalled for 1 ms.

Behaviour:
- Reset (reset==0 at a clock edge): tokens=0, inflight=0, tick counter=0, stall counter=0, reg_tx_frm_cnt=0, reg_shaper_err=0. tx_req_rdy is therefore 0 while shaping is enabled. Reset mid-frame drops all state; no tx_done is expected afterwards.
- Tick:
  - The counter counts 0..cfg-1. tick=1 for one cycle when cnt==cfg-1, and the counter then returns to 0.
  - cfg of 0 or 1 gives a tick every cycle.
  - A cfg change takes effect without restart. If cnt is already >= the new cfg-1, tick fires and cnt returns to 0.
- tx_req_rdy = (!reg_shaper_en | tokens >= tx_req_len) & (inflight < MAX_INFLIGHT).
  - Combinational from registered state and tx_req_len; never depends on tx_req_vld.
- accept = tx_req_vld & tx_req_rdy.
- Token update, one cycle:
  - t = tokens - (accept & en ? len : 0) + (tick ? rate : 0), computed at TOKEN_WIDTH+1 bits.
  - tokens <= min(t, depth). The subtraction cannot underflow because rdy guarantees tokens >= len.
  - A depth lowered below the current tokens clamps on the next cycle.
  - A same-cycle accept and tick both apply.
- Shaping disabled: tokens <= depth every cycle, so re-enabling starts full.
- Inflight count:
  - +1 on accept, -1 on tx_done; both in the same cycle leave it unchanged.
  - tx_done with inflight==0 keeps it at 0 and sets err[0].
- reg_tx_frm_cnt increments by 1 on each accept and wraps modulo 2^32.
- Stall:
  - The counter counts ticks while tx_req_vld & !tx_req_rdy, and clears to 0 whenever that condition is false.
  - On reaching STALL_MS_US it sets err[1] and saturates.
- Errors are sticky. reg_err_clr clears them; a set event in the same cycle as a clear wins.
- A length-0 request is accepted whenever inflight < MAX_INFLIGHT.
- All outputs except tx_req_rdy are registered.

Decomposition:
- Package mmu_tx_pkg holds LEN_WIDTH, TOKEN_WIDTH, MAX_INFLIGHT, the error bit indices ERR_DONE_UFLOW=0 and ERR_STALL=1, and STALL_MS_US.
- Sub-module mmu_tick_gen (cfg in, tick out, synchronous active-low reset) is reusable by the RX side.
- Token, in-flight, stall and counter logic live in mmu_tx_shaper.

Test Plan:
1. Reset release, cfg=10, rate=100, depth=1000, en=1 -> rdy=0 until the first tick at cycle 10; tokens reach 1000 after 10 ticks and hold there.
2. Tokens=1000, continuous vld with len=600 -> one accept (tokens=400, rdy=0); rdy rises on the tick where tokens reach >=600 (2 ticks later); frm_cnt=2 after the second accept.
3. Accept of len=300 in the same cycle as a tick with tokens=500, rate=100 -> tokens=300 next cycle; with depth=350 and tokens=340, a tick and no accept -> 350.
4. Issue 64 accepts with no tx_done -> rdy=0 at inflight=64 despite tokens; one tx_done -> rdy=1; tx_done plus accept in the same cycle -> inflight unchanged.
5. tx_done with inflight=0 -> err=2'b01, inflight stays 0; reg_err_clr -> err=0; clear and set in the same cycle -> err[0]=1.
6. en=1, depth=100, len=200 held valid for 1000 ticks -> err[1]=1; set en=0 -> immediate accept, tokens=100 next cycle.

Source files
------------

// File: rtl/mmu_tx_pkg.sv
// Shared constants for the TX token-bucket shaper and its tick generator.
package mmu_tx_pkg;
    localparam int LEN_WIDTH      = 14;
    localparam int TOKEN_WIDTH    = 20;
    localparam int MAX_INFLIGHT   = 64;
    localparam int STALL_MS_US    = 1000;
    localparam int ERR_DONE_UFLOW = 0;
    localparam int ERR_STALL      = 1;
endpackage

// File: rtl/mmu_tick_gen.sv
// 1 us tick generator: pulses once every cfg clock cycles (every cycle for cfg 0/1).
module mmu_tick_gen (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] cfg,
    output logic       tick
);
    logic [7:0] r_cnt;
    logic       w_tick;

    // The >= compare lets a lowered cfg take effect at once instead of waiting for a wrap.
    assign w_tick = (cfg <= 8'd1) || (r_cnt >= (cfg - 8'd1));
    assign tick   = w_tick;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/mmu_tx_shaper.sv
// Token-bucket TX admission shaper with in-flight limiting, frame counter and sticky errors.
module mmu_tx_shaper
    import mmu_tx_pkg::*;
(
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   tx_req_vld,
    input  logic [LEN_WIDTH-1:0]   tx_req_len,
    output logic                   tx_req_rdy,
    input  logic                   tx_done,
    input  logic                   reg_shaper_en,
    input  logic [7:0]             reg_timer_1us_cfg,
    input  logic [15:0]            reg_token_rate,
    input  logic [TOKEN_WIDTH-1:0] reg_token_depth,
    input  logic                   reg_err_clr,
    output logic [31:0]            reg_tx_frm_cnt,
    output logic [6:0]             reg_inflight_cnt,
    output logic [1:0]             reg_shaper_err
);
    localparam int TW1 = TOKEN_WIDTH + 1;
    localparam int SW  = $clog2(STALL_MS_US + 1);

    logic                   w_tick;
    logic                   w_accept;
    logic                   w_tok_ok;
    logic                   w_room;
    logic                   w_stall_cond;
    logic [TW1-1:0]         w_tok_sum;
    logic [TOKEN_WIDTH-1:0] w_tok_next;
    logic [1:0]             w_err_set;

    logic [TOKEN_WIDTH-1:0] r_tokens;
    logic [6:0]             r_inflight;
    logic [SW-1:0]          r_stall_cnt;
    logic [31:0]            r_frm_cnt;
    logic [1:0]             r_err;

    mmu_tick_gen u_tick (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cfg     (reg_timer_1us_cfg),
        .tick    (w_tick)
    );

    assign w_tok_ok     = !reg_shaper_en || (r_tokens >= TOKEN_WIDTH'(tx_req_len));
    assign w_room       = r_inflight < 7'(MAX_INFLIGHT);
    assign tx_req_rdy   = w_tok_ok && w_room;
    assign w_accept     = tx_req_vld && tx_req_rdy;
    assign w_stall_cond = tx_req_vld && !tx_req_rdy;

    // One bit of headroom so a tick refill above depth is seen before clamping.
    always_comb begin
        w_tok_sum = {1'b0, r_tokens}
                  - ((w_accept && reg_shaper_en) ? TW1'(tx_req_len) : TW1'(0))
                  + (w_tick ? TW1'(reg_token_rate) : TW1'(0));
        if (!reg_shaper_en) begin
            w_tok_next = reg_token_depth;
        end else if (w_tok_sum > {1'b0, reg_token_depth}) begin
            w_tok_next = reg_token_depth;
        end else begin
            w_tok_next = w_tok_sum[TOKEN_WIDTH-1:0];
        end
    end

    always_comb begin
        w_err_set                 = '0;
        w_err_set[ERR_DONE_UFLOW] = tx_done && (r_inflight == 7'd0);
        w_err_set[ERR_STALL]      = w_stall_cond && w_tick
                                  && (r_stall_cnt == SW'(STALL_MS_US - 1));
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_tokens    <= '0;
            r_inflight  <= '0;
            r_stall_cnt <= '0;
            r_frm_cnt   <= '0;
            r_err       <= '0;
        end else begin
            r_tokens <= w_tok_next;

            case ({w_accept, tx_done})
                2'b10:   r_inflight <= r_inflight + 7'd1;
                2'b01:   r_inflight <= (r_inflight == 7'd0) ? 7'd0 : r_inflight - 7'd1;
                default: r_inflight <= r_inflight;
            endcase

            if (!w_stall_cond) begin
                r_stall_cnt <= '0;
            end else if (w_tick && (r_stall_cnt != SW'(STALL_MS_US))) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end

            if (w_accept) begin
                r_frm_cnt <= r_frm_cnt + 32'd1;
            end

            r_err <= (reg_err_clr ? 2'b00 : r_err) | w_err_set;
        end
    end

    assign reg_tx_frm_cnt   = r_frm_cnt;
    assign reg_inflight_cnt = r_inflight;
    assign reg_shaper_err   = r_err;
endmodule

// File: tb/tb_mmu_tx_shaper.sv
// Directed bench for mmu_tx_shaper: expected accepts are queued, a monitor checks each one.
module tb_mmu_tx_shaper;
    import mmu_tx_pkg::*;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic                   tx_req_vld;
    logic [LEN_WIDTH-1:0]   tx_req_len;
    logic                   tx_req_rdy;
    logic                   tx_done;
    logic                   reg_shaper_en;
    logic [7:0]             reg_timer_1us_cfg;
    logic [15:0]            reg_token_rate;
    logic [TOKEN_WIDTH-1:0] reg_token_depth;
    logic                   reg_err_clr;
    logic [31:0]            reg_tx_frm_cnt;
    logic [6:0]             reg_inflight_cnt;
    logic [1:0]             reg_shaper_err;

    always #5 clk_sys = ~clk_sys;

    mmu_tx_shaper dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .tx_req_vld        (tx_req_vld),
        .tx_req_len        (tx_req_len),
        .tx_req_rdy        (tx_req_rdy),
        .tx_done           (tx_done),
        .reg_shaper_en     (reg_shaper_en),
        .reg_timer_1us_cfg (reg_timer_1us_cfg),
        .reg_token_rate    (reg_token_rate),
        .reg_token_depth   (reg_token_depth),
        .reg_err_clr       (reg_err_clr),
        .reg_tx_frm_cnt    (reg_tx_frm_cnt),
        .reg_inflight_cnt  (reg_inflight_cnt),
        .reg_shaper_err    (reg_shaper_err)
    );

    typedef struct {
        int cyc;
        int len;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   s;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
    endtask

    task automatic at_neg();
        @(negedge clk_sys);
    endtask

    task automatic chk_len(input int l, input logic exp);
        tx_req_len = LEN_WIDTH'(l);
        #1;
        chk($sformatf("rdy_len%0d", l), tx_req_rdy, exp);
    endtask

    task automatic push(input int c, input int l);
        exp_t e;
        e.cyc = c;
        e.len = l;
        sb_q.push_back(e);
    endtask

    // Monitor: every admitted frame must match the next queued expectation.
    always @(negedge clk_sys) begin
        if (reset && tx_req_vld && tx_req_rdy) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL accept_unexpected: got cyc=%0d len=%0d expected none", cyc, tx_req_len);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc == cyc && mon_e.len == int'(tx_req_len)) begin
                    n_pass++;
                    $display("accept cyc=%0d len=%0d ok", cyc, tx_req_len);
                end else begin
                    $display("FAIL accept: got cyc=%0d len=%0d expected cyc=%0d len=%0d",
                             cyc, tx_req_len, mon_e.cyc, mon_e.len);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        reset = 1'b0; tx_req_vld = 1'b0; tx_req_len = LEN_WIDTH'(100); tx_done = 1'b0;
        reg_shaper_en = 1'b1; reg_timer_1us_cfg = 8'd10; reg_token_rate = 16'd100;
        reg_token_depth = TOKEN_WIDTH'(1000); reg_err_clr = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b1;

        // Reset state and first tick
        at_neg();
        chk("rst_rdy", tx_req_rdy, 0);
        chk("rst_frm", reg_tx_frm_cnt, 0);
        chk("rst_inflight", reg_inflight_cnt, 0);
        chk("rst_err", reg_shaper_err, 0);
        goto(9);   at_neg(); chk("rdy_pre_tick", tx_req_rdy, 0);
        goto(10);  at_neg(); chk("rdy_post_tick", tx_req_rdy, 1);
        goto(100); at_neg(); chk_len(1000, 1'b1); chk_len(1001, 1'b0);
        goto(120); at_neg(); chk_len(1000, 1'b1); chk_len(1001, 1'b0);

        // Continuous len=600 requests
        goto(121); tx_req_vld = 1'b1; tx_req_len = LEN_WIDTH'(600);
        push(121, 600); push(140, 600);
        goto(122); at_neg(); chk("rdy_drained", tx_req_rdy, 0);
        goto(139); at_neg(); chk("rdy_before_refill", tx_req_rdy, 0);
        goto(140); at_neg(); chk("rdy_refilled", tx_req_rdy, 1);
        goto(141); tx_req_vld = 1'b0; at_neg();
        chk("frm_cnt_2", reg_tx_frm_cnt, 2);
        chk("inflight_2", reg_inflight_cnt, 2);

        // Accept coincident with tick, then clamp at a lowered depth
        goto(199); tx_req_vld = 1'b1; tx_req_len = LEN_WIDTH'(300); push(199, 300);
        goto(200); tx_req_vld = 1'b0; reg_token_depth = TOKEN_WIDTH'(350); at_neg();
        chk_len(300, 1'b1); chk_len(301, 1'b0);
        goto(201); tx_req_vld = 1'b1; tx_req_len = LEN_WIDTH'(60); push(201, 60);
        goto(202); tx_req_vld = 1'b0;
        goto(210); at_neg(); chk_len(340, 1'b1); chk_len(341, 1'b0);
        goto(220); at_neg(); chk_len(350, 1'b1); chk_len(351, 1'b0);

        // In-flight limit with zero-length frames
        goto(221); tx_req_vld = 1'b1; tx_req_len = '0;
        for (int i = 221; i <= 280; i++) push(i, 0);
        goto(281); at_neg();
        chk("rdy_inflight_full", tx_req_rdy, 0);
        chk("inflight_64", reg_inflight_cnt, 64);
        goto(282); tx_done = 1'b1; at_neg(); chk("rdy_full_done", tx_req_rdy, 0);
        goto(283); push(283, 0); at_neg();
        chk("rdy_after_done", tx_req_rdy, 1);
        chk("inflight_63", reg_inflight_cnt, 63);
        goto(284); tx_req_vld = 1'b0; at_neg();
        chk("inflight_done_accept", reg_inflight_cnt, 63);
        chk("frm_cnt_65", reg_tx_frm_cnt, 65);

        // Drain, then underflow error and clear priority
        goto(347); tx_done = 1'b0; at_neg();
        chk("inflight_drained", reg_inflight_cnt, 0);
        chk("err_none", reg_shaper_err, 0);
        goto(348); tx_done = 1'b1;
        goto(349); tx_done = 1'b0; reg_err_clr = 1'b1; at_neg();
        chk("err_uflow", reg_shaper_err, 1);
        chk("inflight_uflow", reg_inflight_cnt, 0);
        goto(350); tx_done = 1'b1; at_neg(); chk("err_cleared", reg_shaper_err, 0);
        goto(351); tx_done = 1'b0; at_neg(); chk("err_set_wins", reg_shaper_err, 1);
        goto(352); reg_err_clr = 1'b0; reg_token_depth = TOKEN_WIDTH'(100);
        reg_timer_1us_cfg = 8'd1; at_neg(); chk("err_cleared2", reg_shaper_err, 0);

        // Stall for STALL_MS_US ticks, then bypass
        s = 353;
        goto(s); tx_req_vld = 1'b1; tx_req_len = LEN_WIDTH'(200);
        goto(s + STALL_MS_US - 1); at_neg(); chk("stall_not_yet", reg_shaper_err, 0);
        goto(s + STALL_MS_US);     at_neg(); chk("stall_err", reg_shaper_err, 2);
        goto(s + STALL_MS_US + 1); reg_shaper_en = 1'b0; push(s + STALL_MS_US + 1, 200);
        at_neg(); chk("rdy_bypass", tx_req_rdy, 1);
        goto(s + STALL_MS_US + 2); reg_shaper_en = 1'b1; tx_req_vld = 1'b0; at_neg();
        chk_len(100, 1'b1); chk_len(101, 1'b0);
        chk("inflight_1", reg_inflight_cnt, 1);
        chk("frm_cnt_66", reg_tx_frm_cnt, 66);
        reset = 1'b0;

        // Reset mid-frame drops all state
        goto(s + STALL_MS_US + 3); reset = 1'b1; tx_req_len = LEN_WIDTH'(1); at_neg();
        chk("rst2_frm", reg_tx_frm_cnt, 0);
        chk("rst2_inflight", reg_inflight_cnt, 0);
        chk("rst2_err", reg_shaper_err, 0);
        chk("rst2_rdy", tx_req_rdy, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
